// File: rtl/spi_xfer_sched_if.sv
// Requester/master-side signal bundle for spi_xfer_sched.
// The scheduler takes the slave modport; the host side and SPI master hook up through master.
interface spi_xfer_sched_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_dat;
  logic [N_REQ-1:0]   req_cpol;
  logic [N_REQ-1:0]   req_cpha;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic               m_start;
  logic               m_cpol;
  logic               m_cpha;
  logic [7:0]         m_p_dat;
  logic               m_cs;

  modport slave (
    input  req, req_dat, req_cpol, req_cpha, m_cs,
    output gnt, done, err, busy, m_start, m_cpol, m_cpha, m_p_dat
  );

  modport master (
    output req, req_dat, req_cpol, req_cpha, m_cs,
    input  gnt, done, err, busy, m_start, m_cpol, m_cpha, m_p_dat
  );
endinterface

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one SPI master among N_REQ requesters; launches a byte,
// tracks cs for completion and aborts with err if cs never goes low within TIMEOUT cycles.
module spi_xfer_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  spi_xfer_sched_if.slave bus
);
  localparam int unsigned IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitLo, StWaitHi, StFinish, StGap
  } state_e;

  state_e            r_state, w_state_next;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [7:0]        r_p_dat, w_p_dat_next;
  logic              r_cpol, w_cpol_next;
  logic              r_cpha, w_cpha_next;
  logic              r_start, w_start_next;
  logic              r_err_flag, w_err_flag_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic [IdxW-1:0]   r_last, w_last_next;
  logic [IdxW-1:0]   w_win, w_cand;

  // Scan farthest-to-nearest from last winner so the nearest requester overwrites the rest.
  always_comb begin
    w_win  = r_last;
    w_cand = r_last;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      w_cand = IdxW'((int'(r_last) + k) % int'(N_REQ));
      if (bus.req[w_cand]) w_win = w_cand;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_p_dat_next    = r_p_dat;
    w_cpol_next     = r_cpol;
    w_cpha_next     = r_cpha;
    w_start_next    = r_start;
    w_err_flag_next = r_err_flag;
    w_cnt_next      = r_cnt;
    w_last_next     = r_last;
    unique case (r_state)
      StIdle: begin
        if (|bus.req) begin
          w_gnt_next        = '0;
          w_gnt_next[w_win] = 1'b1;
          w_p_dat_next      = bus.req_dat[{w_win, 3'b000} +: 8];
          w_cpol_next       = bus.req_cpol[w_win];
          w_cpha_next       = bus.req_cpha[w_win];
          w_last_next       = w_win;
          w_state_next      = StLaunch;
        end
      end
      StLaunch: begin
        w_start_next = 1'b1;
        w_cnt_next   = '0;
        w_state_next = StWaitLo;
      end
      StWaitLo: begin
        if (!bus.m_cs) begin
          w_start_next = 1'b0;
          w_state_next = StWaitHi;
        end else if (r_cnt == CntMax) begin
          w_start_next    = 1'b0;
          w_err_flag_next = 1'b1;
          w_state_next    = StFinish;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StWaitHi: begin
        if (bus.m_cs) w_state_next = StFinish;
      end
      StFinish: begin
        w_gnt_next      = '0;
        w_err_flag_next = 1'b0;
        w_state_next    = StGap;
      end
      StGap:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_p_dat    <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_start    <= 1'b0;
      r_err_flag <= 1'b0;
      r_cnt      <= '0;
      r_last     <= IdxLast;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_p_dat    <= w_p_dat_next;
      r_cpol     <= w_cpol_next;
      r_cpha     <= w_cpha_next;
      r_start    <= w_start_next;
      r_err_flag <= w_err_flag_next;
      r_cnt      <= w_cnt_next;
      r_last     <= w_last_next;
    end
  end

  // done/err are decoded from registered state and grant only, so req never reaches an output.
  assign bus.gnt     = r_gnt;
  assign bus.done    = (r_state == StFinish) ? r_gnt : '0;
  assign bus.err     = (r_state == StFinish) & r_err_flag;
  assign bus.busy    = (r_state != StIdle);
  assign bus.m_start = r_start;
  assign bus.m_cpol  = r_cpol;
  assign bus.m_cpha  = r_cpha;
  assign bus.m_p_dat = r_p_dat;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized bench for spi_xfer_sched: a transaction-level round-robin model plus a simple
// SPI master model that answers m_start by pulling cs low, or never (timeout).
module tb_spi_xfer_sched;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sched_if #(.N_REQ(N)) bus ();

  spi_xfer_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int last_win = N - 1;
  logic [7:0] exp_dat [N];
  logic       exp_cpol[N];
  logic       exp_cpha[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbiter: first set request after the previous winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[2'((last + k) % N)]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic post(input int i, input logic [7:0] d, input logic cp, input logic ch);
    exp_dat[i]  = d;
    exp_cpol[i] = cp;
    exp_cpha[i] = ch;
    bus.req_dat[{2'(i), 3'b000} +: 8] = d;
    bus.req_cpol[2'(i)] = cp;
    bus.req_cpha[2'(i)] = ch;
    bus.req[2'(i)]      = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // mode: 0 = requester drops req at done, 1 = keeps it, 2 = all requests cleared at done
  task automatic do_xfer(input int dly, input int len, input bit stuck, input bit drop,
                         input int mode);
    int w;
    int n;
    int cnt;
    logic [N-1:0] eg;
    w = rr_pick(bus.req, last_win);
    if (w < 0) begin
      check("no_request", 32'd0, 32'd1);
      return;
    end
    eg = '0;
    eg[2'(w)] = 1'b1;
    wait_grant(n);
    check("grant_latency", 32'(n), 32'd1);
    if (bus.gnt == '0) return;
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
    check("m_p_dat", 32'(bus.m_p_dat), 32'(exp_dat[w]));
    check("m_cpol", 32'(bus.m_cpol), 32'(exp_cpol[w]));
    check("m_cpha", 32'(bus.m_cpha), 32'(exp_cpha[w]));
    check("busy_grant", 32'(bus.busy), 32'd1);
    check("start_at_grant", 32'(bus.m_start), 32'd0);
    last_win = w;
    @(negedge clk);
    check("start_rise", 32'(bus.m_start), 32'd1);
    if (stuck) begin
      cnt = 1;
      while (cnt < 4 * TO) begin
        @(negedge clk);
        if (!bus.m_start) break;
        cnt++;
      end
      check("start_cycles", 32'(cnt), 32'(TO));
    end else begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        if (drop && i == 0) bus.req[2'(w)] = 1'b0;
      end
      check("start_hold", 32'(bus.m_start), 32'd1);
      bus.m_cs = 1'b0;
      @(negedge clk);
      check("start_fall", 32'(bus.m_start), 32'd0);
      check("done_early", 32'(bus.done), 32'd0);
      check("p_dat_held", 32'(bus.m_p_dat), 32'(exp_dat[w]));
      for (int i = 1; i < len; i++) @(negedge clk);
      bus.m_cs = 1'b1;
      @(negedge clk);
    end
    check("done", 32'(bus.done), 32'(eg));
    check("err", 32'(bus.err), 32'(stuck));
    check("gnt_finish", 32'(bus.gnt), 32'(eg));
    if (mode == 0) bus.req[2'(w)] = 1'b0;
    else if (mode == 2) bus.req = '0;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("err_pulse", 32'(bus.err), 32'd0);
    check("gnt_clear", 32'(bus.gnt), 32'd0);
    check("busy_gap", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("start_idle", 32'(bus.m_start), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_start"}, 32'(bus.m_start), 32'd0);
    check({tag, "_cpol"}, 32'(bus.m_cpol), 32'd0);
    check({tag, "_cpha"}, 32'(bus.m_cpha), 32'd0);
    check({tag, "_pdat"}, 32'(bus.m_p_dat), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req      = '0;
    bus.req_dat  = '0;
    bus.req_cpol = '0;
    bus.req_cpha = '0;
    bus.m_cs     = 1'b1;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request, then simultaneous contention.
    post(0, 8'hA5, 1'b1, 1'b0);
    do_xfer(3, 16, 1'b0, 1'b0, 0);
    post(1, 8'h3C, 1'b0, 1'b1);
    post(3, 8'hC3, 1'b1, 1'b1);
    do_xfer(2, 5, 1'b0, 1'b0, 0);
    do_xfer(4, 3, 1'b0, 1'b0, 0);

    // Fairness with all requests held.
    for (int i = 0; i < N; i++) post(i, 8'(8'h10 + i), 1'(i), 1'(i >> 1));
    for (int i = 0; i < 8; i++) do_xfer(2, 4, 1'b0, 1'b0, (i == 7) ? 2 : 1);

    // Timeout with cs stuck high, then request dropped mid-flight.
    post(2, 8'h5A, 1'b0, 1'b0);
    do_xfer(0, 0, 1'b1, 1'b0, 0);
    post(2, 8'h77, 1'b1, 1'b0);
    do_xfer(3, 6, 1'b0, 1'b1, 0);

    // Reset while waiting for cs high.
    post(1, 8'hE1, 1'b1, 1'b1);
    wait_grant(n);
    check("rst_grant_latency", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    bus.m_cs = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    bus.m_cs = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst      = 1'b0;
    last_win = N - 1;
    bus.req  = '0;
    post(3, 8'h33, 1'b0, 1'b1);
    post(1, 8'h11, 1'b1, 1'b0);
    post(0, 8'h00, 1'b1, 1'b1);
    do_xfer(2, 2, 1'b0, 1'b0, 0);
    do_xfer(1, 1, 1'b0, 1'b0, 0);
    do_xfer(5, 7, 1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[2'(i)] && $urandom_range(0, 2) == 0)
          post(i, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      if (bus.req == '0) post(int'($urandom_range(0, N - 1)), 8'($urandom), 1'($urandom),
                              1'($urandom));
      do_xfer(int'($urandom_range(1, 8)), int'($urandom_range(1, 12)),
              ($urandom_range(0, 7) == 0), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
